gpio_serial_loader: RTL and testbench
=====================================

# gpio_serial_loader

Sequencer for the two GPIO configuration shift chains (user 1 and user 2 pad sides) inside housekeeping. On a start request it reads one configuration word per pad, shifts all words serially into both chains in parallel, then pulses the chain load strobe so every pad latches its new setting at once. When idle, an optional bit-bang path passes software-driven chain signals through, replacing hand-toggled SPI register writes.

## Interface
Parameters:
- NPADS, 19, pads per chain
- CFG_WIDTH, 13, configuration bits per pad
- CLK_DIV, 2, wb_clk_i cycles per serial clock half-period (≥1)
- ADDR_W, $clog2(NPADS), width of cfg_addr

Ports:
- wb_clk_i  in  1  system clock
- wb_rstn_i  in  1  reset, asynchronous, active-low
- xfer_start  in  1  single-cycle request to load all pads
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer completion
- cfg_addr  out  ADDR_W  pad index whose word is being shifted
- cfg_data_1  in  CFG_WIDTH  chain-1 word for pad cfg_addr, combinational from register file
- cfg_data_2  in  CFG_WIDTH  chain-2 word for pad cfg_addr
- bb_en  in  1  bit-bang passthrough request
- bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2  in  1 each  bit-bang chain signals
- serial_clock  out  1  chain shift clock
- serial_load  out  1  chain load strobe
- serial_resetn  out  1  chain reset, active-low
- serial_data_1  out  1  chain-1 serial data
- serial_data_2  out  1  chain-2 serial data

## Operation
- All outputs registered. FSM states: IDLE, SHIFT_LO, SHIFT_HI, LOAD_LO, LOAD_HI, DONE.
- IDLE: cfg_addr = NPADS-1; serial_resetn = 1; serial_clock/serial_load = 0. If bb_en=1 (and macro enabled), outputs follow bb_* with one-cycle register latency.
- xfer_start in IDLE → SHIFT_LO, bit counter = CFG_WIDTH-1, pad index = NPADS-1. xfer_start has priority over bb_en.
- SHIFT_LO (CLK_DIV cycles): serial_clock=0, serial_data_n = cfg_data_n[bit]. SHIFT_HI (CLK_DIV cycles): serial_clock=1, data held.
- Order: pad NPADS-1 first, down to pad 0; within a word MSB first. After bit 0 of a word, cfg_addr decrements.
- After bit 0 of pad 0 → LOAD_LO (CLK_DIV cycles, all low), LOAD_HI (CLK_DIV cycles, serial_load=1), DONE (one cycle: done=1, busy=0) → IDLE.
- xfer_start while busy: ignored. bb_* while busy: ignored.
- cfg_data_n sampled each SHIFT_LO entry cycle; register file changes during transfer take effect for later bits only.

## Timing
- Reset values: busy=0, done=0, cfg_addr=NPADS-1, serial_clock=0, serial_load=0, serial_resetn=0, serial_data_1/2=0, FSM=IDLE. serial_resetn rises first clock after wb_rstn_i deasserts.
- busy asserts cycle after xfer_start; busy length = NPADS·CFG_WIDTH·2·CLK_DIV + 2·CLK_DIV cycles (992 at defaults); done coincides with first busy=0 cycle.
- Data stable ≥CLK_DIV cycles before and after every serial_clock rising edge.
- Exactly NPADS·CFG_WIDTH serial_clock rising edges and one serial_load pulse per transfer.
- Reset mid-transfer: outputs asynchronously to reset values; no serial_load pulse; chain contents unlatched; next xfer_start restarts from pad NPADS-1.

## Configuration
- GPIO_LOADER_BITBANG_EN: defined → bit-bang passthrough in IDLE as above. Undefined → bb_* ports present but ignored; IDLE outputs fixed at serial_clock=0, serial_load=0, serial_resetn=1, data=0.

## Test plan
- Reset: hold wb_rstn_i=0 → all outputs at listed reset values; release → serial_resetn=1 next cycle, busy=0.
- Full load, defaults: cfg_data_1 = {pad index, 8'hA5}, cfg_data_2 = bitwise inverse; capture data on serial_clock rises → 247 bits equal pad18..pad0 MSB-first on each chain; one serial_load pulse after last edge; busy 992 cycles; one done pulse.
- Second xfer_start at busy cycle 100 → still 247 edges, single done, busy 992 cycles.
- wb_rstn_i low after 50th serial_clock edge → outputs reset immediately, no serial_load; new xfer_start completes full 247-bit transfer.
- Macro defined, bb_en=1 idle, toggle bb_clock/bb_data_1/bb_load → outputs follow one cycle later; xfer_start with bb_en=1 → loader owns outputs until done. Macro undefined → no output activity from bb_*.
- CLK_DIV=1: busy 496 cycles, serial_clock half-period 1 cycle, same 247-bit sequence.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// gpio_serial_loader: shifts one config word per pad into both GPIO chains, then strobes serial_load.
// Define GPIO_LOADER_BITBANG_EN to pass bb_* through to the chain outputs while idle.
module gpio_serial_loader #(
   parameter int NPADS     = 19,
   parameter int CFG_WIDTH = 13,
   parameter int CLK_DIV   = 2,
   parameter int ADDR_W    = $clog2(NPADS)
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rstn_i,
   input  logic                 xfer_start,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    cfg_addr,
   input  logic [CFG_WIDTH-1:0] cfg_data_1,
   input  logic [CFG_WIDTH-1:0] cfg_data_2,
   input  logic                 bb_en,
   input  logic                 bb_clock,
   input  logic                 bb_load,
   input  logic                 bb_resetn,
   input  logic                 bb_data_1,
   input  logic                 bb_data_2,
   output logic                 serial_clock,
   output logic                 serial_load,
   output logic                 serial_resetn,
   output logic                 serial_data_1,
   output logic                 serial_data_2
);
   localparam logic [2:0] IDLE = 3'd0, SHIFT_LO = 3'd1, SHIFT_HI = 3'd2,
                          LOAD_LO = 3'd3, LOAD_HI = 3'd4, DONE = 3'd5;
   localparam int BW = CFG_WIDTH > 1 ? $clog2(CFG_WIDTH) : 1;
   localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_RELOAD = DW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BIT_TOP = BW'(CFG_WIDTH - 1);
   localparam logic [ADDR_W-1:0] PAD_TOP = ADDR_W'(NPADS - 1);

   logic [2:0]        state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [ADDR_W-1:0] pad_q, pad_d, addr_q, addr_d;
   logic busy_q, busy_d, done_q, done_d, sclk_q, sclk_d, sload_q, sload_d;
   logic sresetn_q, sresetn_d, sd1_q, sd1_d, sd2_q, sd2_d;
   logic bb_act, idle_bb;

`ifdef GPIO_LOADER_BITBANG_EN
   assign bb_act = bb_en;
`else
   logic bb_unused;
   assign bb_act    = 1'b0;
   assign bb_unused = ^{bb_en, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2};
`endif

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      pad_d   = pad_q;
      addr_d  = addr_q;
      sd1_d   = sd1_q;
      sd2_d   = sd2_q;
      if (state_q != IDLE && state_q != DONE && div_q != '0) begin
         div_d = div_q - 1'b1;
      end else begin
         unique case (state_q)
            IDLE: if (xfer_start) begin
               state_d = SHIFT_LO;
               div_d   = DIV_RELOAD;
               bit_d   = BIT_TOP;
               pad_d   = PAD_TOP;
               sd1_d   = cfg_data_1[CFG_WIDTH-1];
               sd2_d   = cfg_data_2[CFG_WIDTH-1];
            end
            SHIFT_LO: begin
               state_d = SHIFT_HI;
               div_d   = DIV_RELOAD;
               // move cfg_addr early so the next word is settled before the next SHIFT_LO samples it
               if (bit_q == '0) addr_d = pad_q == '0 ? PAD_TOP : pad_q - 1'b1;
            end
            SHIFT_HI: begin
               div_d = DIV_RELOAD;
               if (bit_q == '0 && pad_q == '0) begin
                  state_d = LOAD_LO;
               end else begin
                  state_d = SHIFT_LO;
                  bit_d   = bit_q == '0 ? BIT_TOP : bit_q - 1'b1;
                  pad_d   = bit_q == '0 ? pad_q - 1'b1 : pad_q;
                  sd1_d   = cfg_data_1[bit_d];
                  sd2_d   = cfg_data_2[bit_d];
               end
            end
            LOAD_LO: begin
               state_d = LOAD_HI;
               div_d   = DIV_RELOAD;
            end
            LOAD_HI: state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
      idle_bb   = state_d == IDLE && bb_act;
      busy_d    = state_d inside {SHIFT_LO, SHIFT_HI, LOAD_LO, LOAD_HI};
      done_d    = state_d == DONE;
      sclk_d    = idle_bb ? bb_clock : state_d == SHIFT_HI;
      sload_d   = idle_bb ? bb_load : state_d == LOAD_HI;
      sresetn_d = idle_bb ? bb_resetn : 1'b1;
      if (!(state_d inside {SHIFT_LO, SHIFT_HI})) begin
         sd1_d = idle_bb ? bb_data_1 : 1'b0;
         sd2_d = idle_bb ? bb_data_2 : 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
      if (!wb_rstn_i) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         pad_q     <= PAD_TOP;
         addr_q    <= PAD_TOP;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sclk_q    <= 1'b0;
         sload_q   <= 1'b0;
         sresetn_q <= 1'b0;
         sd1_q     <= 1'b0;
         sd2_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         pad_q     <= pad_d;
         addr_q    <= addr_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sclk_q    <= sclk_d;
         sload_q   <= sload_d;
         sresetn_q <= sresetn_d;
         sd1_q     <= sd1_d;
         sd2_q     <= sd2_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign cfg_addr      = addr_q;
   assign serial_clock  = sclk_q;
   assign serial_load   = sload_q;
   assign serial_resetn = sresetn_q;
   assign serial_data_1 = sd1_q;
   assign serial_data_2 = sd2_q;
endmodule

// File: tb/tb_gpio_serial_loader.sv
// tb_gpio_serial_loader: checks chain bit order, timing and bit-bang passthrough at CLK_DIV=2 and CLK_DIV=1.
module tb_gpio_serial_loader;
   localparam int NPADS = 19;
   localparam int CFG_WIDTH = 13;
   localparam int NBITS = NPADS * CFG_WIDTH;
`ifdef GPIO_LOADER_BITBANG_EN
   localparam bit BB_ON = 1'b1;
`else
   localparam bit BB_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic xfer_start = 1'b0;
   logic bb_en = 1'b0, bb_clock = 1'b0, bb_load = 1'b0, bb_resetn = 1'b1;
   logic bb_data_1 = 1'b0, bb_data_2 = 1'b0;
   logic busy_a, done_a, sclk_a, sload_a, sres_a, sd1_a, sd2_a;
   logic busy_b, done_b, sclk_b, sload_b, sres_b, sd1_b, sd2_b;
   logic [4:0] addr_a, addr_b;
   logic [CFG_WIDTH-1:0] cfg1_a, cfg2_a, cfg1_b, cfg2_b;

   int tests = 0, fails = 0;
   int edges_a, loads_a, dones_a, busyn_a, mism_a;
   int edges_b, loads_b, dones_b, busyn_b, mism_b;
   bit q1a[$], q2a[$], q1b[$], q2b[$];
   bit pc_a, pl_a, pc_b, pl_b, e1, e2, f1, f2;

   always #5 clk = ~clk;

   assign cfg1_a = {addr_a, 8'hA5};
   assign cfg2_a = ~cfg1_a;
   assign cfg1_b = {addr_b, 8'hA5};
   assign cfg2_b = ~cfg1_b;

   gpio_serial_loader #(.NPADS(NPADS), .CFG_WIDTH(CFG_WIDTH), .CLK_DIV(2)) dut_a (
      .wb_clk_i(clk), .wb_rstn_i(rstn), .xfer_start(xfer_start), .busy(busy_a), .done(done_a),
      .cfg_addr(addr_a), .cfg_data_1(cfg1_a), .cfg_data_2(cfg2_a), .bb_en(bb_en),
      .bb_clock(bb_clock), .bb_load(bb_load), .bb_resetn(bb_resetn), .bb_data_1(bb_data_1),
      .bb_data_2(bb_data_2), .serial_clock(sclk_a), .serial_load(sload_a),
      .serial_resetn(sres_a), .serial_data_1(sd1_a), .serial_data_2(sd2_a));

   gpio_serial_loader #(.NPADS(NPADS), .CFG_WIDTH(CFG_WIDTH), .CLK_DIV(1)) dut_b (
      .wb_clk_i(clk), .wb_rstn_i(rstn), .xfer_start(xfer_start), .busy(busy_b), .done(done_b),
      .cfg_addr(addr_b), .cfg_data_1(cfg1_b), .cfg_data_2(cfg2_b), .bb_en(bb_en),
      .bb_clock(bb_clock), .bb_load(bb_load), .bb_resetn(bb_resetn), .bb_data_1(bb_data_1),
      .bb_data_2(bb_data_2), .serial_clock(sclk_b), .serial_load(sload_b),
      .serial_resetn(sres_b), .serial_data_1(sd1_b), .serial_data_2(sd2_b));

   // scoreboard side: each serial_clock rise pops the expected chain bits
   always @(negedge clk) begin
      if (!rstn) begin
         pc_a = 1'b0; pl_a = 1'b0; pc_b = 1'b0; pl_b = 1'b0;
      end else begin
         if (sclk_a && !pc_a) begin
            edges_a++;
            if (q1a.size() == 0) mism_a++;
            else begin
               e1 = q1a.pop_front(); e2 = q2a.pop_front();
               if (sd1_a !== e1 || sd2_a !== e2) mism_a++;
            end
         end
         if (sload_a && !pl_a) begin loads_a++; if (edges_a != NBITS) mism_a++; end
         if (done_a) begin dones_a++; if (busy_a) mism_a++; end
         if (busy_a) busyn_a++;
         pc_a = sclk_a; pl_a = sload_a;
         if (sclk_b && !pc_b) begin
            edges_b++;
            if (q1b.size() == 0) mism_b++;
            else begin
               f1 = q1b.pop_front(); f2 = q2b.pop_front();
               if (sd1_b !== f1 || sd2_b !== f2) mism_b++;
            end
         end
         if (sload_b && !pl_b) begin loads_b++; if (edges_b != NBITS) mism_b++; end
         if (done_b) begin dones_b++; if (busy_b) mism_b++; end
         if (busy_b) busyn_b++;
         pc_b = sclk_b; pl_b = sload_b;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic clear_counts();
      edges_a = 0; loads_a = 0; dones_a = 0; busyn_a = 0; mism_a = 0;
      edges_b = 0; loads_b = 0; dones_b = 0; busyn_b = 0; mism_b = 0;
      q1a.delete(); q2a.delete(); q1b.delete(); q2b.delete();
   endtask

   task automatic push_exp();
      logic [CFG_WIDTH-1:0] w;
      for (int p = NPADS - 1; p >= 0; p--) begin
         w = {5'(p), 8'hA5};
         for (int b = CFG_WIDTH - 1; b >= 0; b--) begin
            q1a.push_back(w[b]); q2a.push_back(~w[b]);
            q1b.push_back(w[b]); q2b.push_back(~w[b]);
         end
      end
   endtask

   task automatic run_xfer(input string tag, input bit second, input bit tog);
      @(posedge clk); #1;
      clear_counts();
      push_exp();
      xfer_start = 1'b1;
      @(posedge clk); #1;
      xfer_start = 1'b0;
      for (int i = 0; i < 3000 && !(dones_a > 0 && dones_b > 0); i++) begin
         @(posedge clk); #1;
         xfer_start = second && i == 99;
         if (tog) bb_clock = i < 300 ? i[0] : 1'b0;
      end
      xfer_start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk({tag, " finished"}, int'(dones_a > 0 && dones_b > 0), 1);
      chk({tag, " edges_a"}, edges_a, NBITS);
      chk({tag, " edges_b"}, edges_b, NBITS);
      chk({tag, " bit_errs_a"}, mism_a, 0);
      chk({tag, " bit_errs_b"}, mism_b, 0);
      chk({tag, " loads_a"}, loads_a, 1);
      chk({tag, " loads_b"}, loads_b, 1);
      chk({tag, " dones_a"}, dones_a, 1);
      chk({tag, " dones_b"}, dones_b, 1);
      chk({tag, " busy_cycles_a"}, busyn_a, NBITS * 4 + 4);
      chk({tag, " busy_cycles_b"}, busyn_b, NBITS * 2 + 2);
      chk({tag, " left_a"}, q1a.size(), 0);
      chk({tag, " addr_idle_a"}, int'(addr_a), NPADS - 1);
   endtask

   typedef struct {
      logic       en;
      logic [4:0] bb;
      logic [4:0] exp;
   } vec_t;
   vec_t tbl[8];

   initial begin
      tbl[0].en = 1'b0; tbl[0].bb = 5'b11011;
      tbl[1].en = 1'b1; tbl[1].bb = 5'b10100;
      tbl[2].en = 1'b1; tbl[2].bb = 5'b00110;
      tbl[3].en = 1'b1; tbl[3].bb = 5'b11101;
      tbl[4].en = 1'b1; tbl[4].bb = 5'b00011;
      tbl[5].en = 1'b1; tbl[5].bb = 5'b01100;
      tbl[6].en = 1'b0; tbl[6].bb = 5'b10010;
      tbl[7].en = 1'b1; tbl[7].bb = 5'b00100;
      foreach (tbl[i]) tbl[i].exp = (BB_ON && tbl[i].en) ? tbl[i].bb : 5'b00100;
      clear_counts();

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst busy", busy_a, 0);
      chk("rst done", done_a, 0);
      chk("rst addr", int'(addr_a), NPADS - 1);
      chk("rst outs", int'({sclk_a, sload_a, sres_a, sd1_a, sd2_a}), 0);
      chk("rst outs_b", int'({sclk_b, sload_b, sres_b, sd1_b, sd2_b}), 0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("rel resetn", sres_a, 1);
      chk("rel busy", busy_a, 0);

      foreach (tbl[i]) begin
         @(posedge clk); #1;
         bb_en = tbl[i].en;
         {bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = tbl[i].bb;
         @(posedge clk); @(negedge clk);
         chk($sformatf("bb_vec%0d_a", i), int'({sclk_a, sload_a, sres_a, sd1_a, sd2_a}), int'(tbl[i].exp));
         chk($sformatf("bb_vec%0d_b", i), int'({sclk_b, sload_b, sres_b, sd1_b, sd2_b}), int'(tbl[i].exp));
      end
      @(posedge clk); #1;
      {bb_en, bb_clock, bb_load, bb_resetn, bb_data_1, bb_data_2} = 6'b000100;
      repeat (2) @(posedge clk);

      run_xfer("plain", 1'b0, 1'b0);
      run_xfer("restart_ignored", 1'b1, 1'b0);

      @(posedge clk); #1;
      clear_counts();
      push_exp();
      xfer_start = 1'b1;
      @(posedge clk); #1;
      xfer_start = 1'b0;
      for (int i = 0; i < 2000 && edges_a < 50; i++) begin
         @(posedge clk); #1;
      end
      chk("abort reached50", edges_a, 50);
      rstn = 1'b0;
      #1;
      chk("abort busy", busy_a, 0);
      chk("abort addr", int'(addr_a), NPADS - 1);
      chk("abort outs", int'({sclk_a, sload_a, sres_a, sd1_a, sd2_a}), 0);
      chk("abort loads", loads_a + loads_b, 0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      bb_en = 1'b1; bb_data_1 = 1'b1; bb_data_2 = 1'b0;
      repeat (2) @(posedge clk);
      run_xfer("after_abort_bb", 1'b0, 1'b1);
      chk("bb after done", sd1_a, int'(BB_ON));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
